soc_or1k_trace_event_monitor: RTL and testbench

- Parametrised multi-core successor to the single-core r3/termination tracking in the compute-tile simulation bench.
- Watches per-core mor1kx execution trace streams and keeps a shadow copy of r3 for each core.
- Decodes simulation l.nop K instructions (exit, report, putc) into events and serialises them round-robin through an event FIFO with a valid/ready interface.
- Tracks per-core termination, all-cores-done, event overflow and a global timeout. Instantiated beside soc_or1k_tile in simulation tops.

---
 rtl/soc_or1k_trace_event_monitor_if.sv | 27 ++
 rtl/soc_or1k_trace_event_monitor.sv | 209 ++++++++++++++++++++
 tb/tb_soc_or1k_trace_event_monitor.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/soc_or1k_trace_event_monitor_if.sv
// Trace-in / event-out bundle for soc_or1k_trace_event_monitor.
// The master side drives trace streams and accepts events; the slave side is the monitor.
interface soc_or1k_trace_event_monitor_if #(
  parameter int unsigned NUM_CORES = 4
) ();
  logic [NUM_CORES-1:0]    trace_valid;
  logic [NUM_CORES*32-1:0] trace_insn;
  logic [NUM_CORES-1:0]    trace_wben;
  logic [NUM_CORES*5-1:0]  trace_wbreg;
  logic [NUM_CORES*32-1:0] trace_wbdata;

  logic        evt_valid;
  logic        evt_ready;
  logic [3:0]  evt_core;
  logic [1:0]  evt_type;
  logic [31:0] evt_data;

  modport master (
    output trace_valid, trace_insn, trace_wben, trace_wbreg, trace_wbdata, evt_ready,
    input  evt_valid, evt_core, evt_type, evt_data
  );

  modport slave (
    input  trace_valid, trace_insn, trace_wben, trace_wbreg, trace_wbdata, evt_ready,
    output evt_valid, evt_core, evt_type, evt_data
  );
endinterface

// File: rtl/soc_or1k_trace_event_monitor.sv
// Multi-core mor1kx trace monitor: shadows r3, decodes simulation l.nop events and
// serialises them round-robin through an event FIFO; tracks exit, overflow and timeout.
module soc_or1k_trace_event_monitor #(
  parameter int unsigned NUM_CORES      = 4,
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 0,
  parameter logic [15:0] NOP_EXIT       = 16'h0001,
  parameter logic [15:0] NOP_REPORT     = 16'h0002,
  parameter logic [15:0] NOP_PUTC       = 16'h0004
) (
  input  logic                          clk,
  input  logic                          rst,
  soc_or1k_trace_event_monitor_if.slave bus,
  output logic [NUM_CORES-1:0]          core_terminated,
  output logic                          all_done,
  output logic                          overflow,
  output logic [15:0]                   drop_count,
  output logic                          timeout
);
  localparam int unsigned IW = 4;
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned NW = 5;

  localparam logic [1:0] KIND_EXIT   = 2'd0;
  localparam logic [1:0] KIND_REPORT = 2'd1;
  localparam logic [1:0] KIND_PUTC   = 2'd2;

  typedef struct packed {
    logic [1:0]  kind;
    logic [31:0] data;
  } slot_t;

  typedef struct packed {
    logic [IW-1:0] core;
    logic [1:0]    kind;
    logic [31:0]   data;
  } evt_t;

  logic [31:0]          r3_q   [NUM_CORES];
  slot_t                slot_q [NUM_CORES];
  logic [NUM_CORES-1:0] pend_q;
  logic [IW-1:0]        rr_ptr;

  evt_t                 mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [CW-1:0]        count_q;
  logic [CW-1:0]        count_n;
  logic                 valid_q;
  logic [31:0]          cycle_q;

  logic [NUM_CORES-1:0] hit_c;
  logic [NUM_CORES-1:0] wr3_c;
  logic [NUM_CORES-1:0] grant_c;
  logic [NUM_CORES-1:0] drop_c;
  logic [31:0]          fwd_c [NUM_CORES];
  slot_t                dec_c [NUM_CORES];

  logic                 full_c;
  logic                 pop_c;
  logic                 grant_vld;
  logic [IW-1:0]        grant_idx;
  slot_t                grant_slot;
  logic [NW-1:0]        n_drop;
  logic [16:0]          drop_sum;
  evt_t                 head;

  // Per-core decode; a same-cycle write to r3 is forwarded into the event payload.
  for (genvar c = 0; c < NUM_CORES; c++) begin : g_dec
    logic        live;
    logic        nop;
    logic [15:0] imm;
    logic        unused_insn_mid;
    slot_t       dec;

    assign live            = bus.trace_valid[c] & ~core_terminated[c];
    assign wr3_c[c]        = live & bus.trace_wben[c] & (bus.trace_wbreg[5*c +: 5] == 5'd3);
    assign fwd_c[c]        = wr3_c[c] ? bus.trace_wbdata[32*c +: 32] : r3_q[c];
    assign nop             = live & (bus.trace_insn[32*c+24 +: 8] == 8'h15);
    assign imm             = bus.trace_insn[32*c +: 16];
    assign unused_insn_mid = ^bus.trace_insn[32*c+16 +: 8];
    assign hit_c[c]        = nop & ((imm == NOP_EXIT) | (imm == NOP_REPORT) | (imm == NOP_PUTC));

    always_comb begin
      dec.kind = KIND_PUTC;
      dec.data = {24'h0, fwd_c[c][7:0]};
      if (imm == NOP_EXIT) begin
        dec.kind = KIND_EXIT;
        dec.data = fwd_c[c];
      end else if (imm == NOP_REPORT) begin
        dec.kind = KIND_REPORT;
        dec.data = fwd_c[c];
      end
    end

    assign dec_c[c] = dec;
  end

  assign full_c = (count_q == CW'(FIFO_DEPTH));
  assign pop_c  = valid_q & bus.evt_ready;

  // Round-robin from rr_ptr; a full FIFO still accepts a push when it pops this cycle.
  always_comb begin : arb
    grant_vld  = 1'b0;
    grant_idx  = '0;
    grant_slot = '0;
    grant_c    = '0;
    for (int c = 0; c < NUM_CORES; c++) begin
      if (!grant_vld && pend_q[c] && (IW'(c) >= rr_ptr)) begin
        grant_vld  = 1'b1;
        grant_idx  = IW'(c);
        grant_slot = slot_q[c];
      end
    end
    for (int c = 0; c < NUM_CORES; c++) begin
      if (!grant_vld && pend_q[c]) begin
        grant_vld  = 1'b1;
        grant_idx  = IW'(c);
        grant_slot = slot_q[c];
      end
    end
    if (full_c && !pop_c) grant_vld = 1'b0;
    for (int c = 0; c < NUM_CORES; c++) grant_c[c] = grant_vld && (grant_idx == IW'(c));
  end

  always_comb begin : drops
    drop_c = '0;
    n_drop = '0;
    for (int c = 0; c < NUM_CORES; c++) begin
      drop_c[c] = hit_c[c] & pend_q[c] & ~grant_c[c];
      n_drop    = n_drop + NW'(drop_c[c]);
    end
    drop_sum = {1'b0, drop_count} + 17'(n_drop);
  end

  assign count_n = count_q + CW'(grant_vld) - CW'(pop_c);

  // r3 shadows, pending slots, termination and the arbitration pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < NUM_CORES; c++) begin
        r3_q[c]   <= '0;
        slot_q[c] <= '0;
      end
      pend_q          <= '0;
      core_terminated <= '0;
      rr_ptr          <= '0;
    end else begin
      for (int c = 0; c < NUM_CORES; c++) begin
        if (wr3_c[c]) r3_q[c] <= fwd_c[c];
        if (hit_c[c] && (!pend_q[c] || grant_c[c])) begin
          pend_q[c] <= 1'b1;
          slot_q[c] <= dec_c[c];
        end else if (grant_c[c]) begin
          pend_q[c] <= 1'b0;
        end
        if (hit_c[c] && (dec_c[c].kind == KIND_EXIT)) core_terminated[c] <= 1'b1;
      end
      if (grant_vld) rr_ptr <= (grant_idx == IW'(NUM_CORES - 1)) ? '0 : grant_idx + IW'(1);
    end
  end

  // Event FIFO; the head entry drives evt_* directly.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
    end else begin
      if (grant_vld) begin
        mem_q[wr_ptr].core <= grant_idx;
        mem_q[wr_ptr].kind <= grant_slot.kind;
        mem_q[wr_ptr].data <= grant_slot.data;
        wr_ptr             <= wr_ptr + AW'(1);
      end
      if (pop_c) rd_ptr <= rd_ptr + AW'(1);
      count_q <= count_n;
      valid_q <= (count_n != '0);
    end
  end

  // Overflow, completion and timeout status.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow   <= 1'b0;
      drop_count <= '0;
      all_done   <= 1'b0;
      timeout    <= 1'b0;
      cycle_q    <= '0;
    end else begin
      if (n_drop != '0) overflow <= 1'b1;
      drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      if ((&core_terminated) && (pend_q == '0) && (count_q == '0)) all_done <= 1'b1;
      if (!all_done && !timeout) begin
        cycle_q <= cycle_q + 32'd1;
        if ((TIMEOUT_CYCLES != 0) && (cycle_q + 32'd1 == 32'(TIMEOUT_CYCLES))) timeout <= 1'b1;
      end
    end
  end

  assign head          = mem_q[rd_ptr];
  assign bus.evt_valid = valid_q;
  assign bus.evt_core  = head.core;
  assign bus.evt_type  = head.kind;
  assign bus.evt_data  = head.data;
endmodule

// File: tb/tb_soc_or1k_trace_event_monitor.sv
// Bench for soc_or1k_trace_event_monitor: directed scenarios plus random traffic,
// compared every cycle against a queue-based event model.
module tb_soc_or1k_trace_event_monitor;
  localparam int unsigned NC    = 4;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned TMO   = 100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  soc_or1k_trace_event_monitor_if #(.NUM_CORES(NC)) bus ();

  logic [NC-1:0] core_terminated;
  logic          all_done;
  logic          overflow;
  logic [15:0]   drop_count;
  logic          timeout;

  soc_or1k_trace_event_monitor #(
    .NUM_CORES(NC), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .core_terminated(core_terminated), .all_done(all_done), .overflow(overflow),
    .drop_count(drop_count), .timeout(timeout)
  );

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { int core; int kind; logic [31:0] data; } ev_t;
  ev_t         m_fifo[$];
  logic [31:0] m_r3 [NC];
  bit          m_pv [NC];
  int          m_pk [NC];
  logic [31:0] m_pd [NC];
  bit [NC-1:0] m_term;
  bit          m_done, m_ovf, m_to, model_on;
  int          m_drops, m_ptr;
  longint      m_cnt;

  task automatic model_step();
    bit pop, can, quiet, hit;
    int g, ndrop, kind;
    logic [31:0] r3, ins;
    ev_t e;
    if (rst) begin
      m_fifo.delete();
      for (int c = 0; c < NC; c++) begin m_r3[c] = 0; m_pv[c] = 0; m_pk[c] = 0; m_pd[c] = 0; end
      m_term = '0; m_done = 0; m_ovf = 0; m_to = 0; m_drops = 0; m_ptr = 0; m_cnt = 0;
      model_on = 1;
      return;
    end
    quiet = (m_term == '1) && (m_fifo.size() == 0);
    for (int c = 0; c < NC; c++) if (m_pv[c]) quiet = 0;
    if (!m_done && !m_to) begin
      m_cnt++;
      if (TMO != 0 && m_cnt == TMO) m_to = 1;
    end
    if (quiet) m_done = 1;
    pop = (m_fifo.size() != 0) && bus.evt_ready;
    can = (m_fifo.size() < DEPTH) || pop;
    g = -1;
    if (can)
      for (int k = 0; k < NC; k++)
        if (g < 0 && m_pv[(m_ptr + k) % NC]) g = (m_ptr + k) % NC;
    if (pop) e = m_fifo.pop_front();
    if (g >= 0) begin
      e.core = g; e.kind = m_pk[g]; e.data = m_pd[g];
      m_fifo.push_back(e);
      m_pv[g] = 0;
      m_ptr = (g + 1) % NC;
    end
    ndrop = 0;
    for (int c = 0; c < NC; c++) begin
      if (bus.trace_valid[c] && !m_term[c]) begin
        ins = bus.trace_insn[32*c +: 32];
        r3  = m_r3[c];
        if (bus.trace_wben[c] && bus.trace_wbreg[5*c +: 5] == 5'd3) r3 = bus.trace_wbdata[32*c +: 32];
        m_r3[c] = r3;
        hit = 0; kind = 0;
        if (ins[31:24] == 8'h15) begin
          if (ins[15:0] == 16'h0001) begin hit = 1; kind = 0; end
          else if (ins[15:0] == 16'h0002) begin hit = 1; kind = 1; end
          else if (ins[15:0] == 16'h0004) begin hit = 1; kind = 2; end
        end
        if (hit) begin
          if (m_pv[c]) ndrop++;
          else begin
            m_pv[c] = 1; m_pk[c] = kind;
            m_pd[c] = (kind == 2) ? {24'h0, r3[7:0]} : r3;
          end
          if (kind == 0) m_term[c] = 1;
        end
      end
    end
    m_drops = (m_drops + ndrop > 65535) ? 65535 : m_drops + ndrop;
    if (ndrop > 0) m_ovf = 1;
  endtask

  always @(posedge clk) model_step();

  always @(negedge clk) begin
    if (model_on) begin
      chk("evt_valid", bus.evt_valid, 64'(m_fifo.size() != 0));
      if (m_fifo.size() != 0) begin
        chk("evt_core", bus.evt_core, 64'(m_fifo[0].core));
        chk("evt_type", bus.evt_type, 64'(m_fifo[0].kind));
        chk("evt_data", bus.evt_data, 64'(m_fifo[0].data));
      end
      chk("core_terminated", core_terminated, 64'(m_term));
      chk("all_done", all_done, 64'(m_done));
      chk("overflow", overflow, 64'(m_ovf));
      chk("drop_count", drop_count, 64'(m_drops));
      chk("timeout", timeout, 64'(m_to));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic clear_trace();
    bus.trace_valid  = '0;
    bus.trace_insn   = '0;
    bus.trace_wben   = '0;
    bus.trace_wbreg  = '0;
    bus.trace_wbdata = '0;
  endtask

  task automatic drive(input int c, input logic [31:0] insn, input logic wben,
                       input logic [4:0] wbreg, input logic [31:0] wbdata);
    bus.trace_valid[c]        = 1'b1;
    bus.trace_insn[32*c +: 32] = insn;
    bus.trace_wben[c]         = wben;
    bus.trace_wbreg[5*c +: 5] = wbreg;
    bus.trace_wbdata[32*c +: 32] = wbdata;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    clear_trace();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    int          got_c[$];
    logic [31:0] got_d[$];
    int          popped;
    logic [31:0] ins;

    clear_trace();
    bus.evt_ready = 1'b1;
    do_reset();

    chk("rst_evt_valid", bus.evt_valid, 0);
    chk("rst_evt_core", bus.evt_core, 0);
    chk("rst_evt_type", bus.evt_type, 0);
    chk("rst_evt_data", bus.evt_data, 0);
    chk("rst_term", core_terminated, 0);
    chk("rst_all_done", all_done, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_drop_count", drop_count, 0);
    chk("rst_timeout", timeout, 0);

    // single putc event, two-cycle latency
    drive(0, 32'h9c60_0041, 1'b1, 5'd3, 32'h41);
    tick();
    drive(0, 32'h1500_0004, 1'b0, 5'd0, 32'h0);
    tick();
    chk("t1_not_yet", bus.evt_valid, 0);
    tick();
    chk("t1_valid", bus.evt_valid, 1);
    chk("t1_core", bus.evt_core, 0);
    chk("t1_type", bus.evt_type, 2);
    chk("t1_data", bus.evt_data, 32'h41);

    // exit with forwarded r3
    drive(1, 32'h1500_0001, 1'b1, 5'd3, 32'h7);
    tick();
    chk("t2_term", core_terminated, 4'b0010);
    tick();
    chk("t2_valid", bus.evt_valid, 1);
    chk("t2_core", bus.evt_core, 1);
    chk("t2_type", bus.evt_type, 0);
    chk("t2_data", bus.evt_data, 32'h7);
    tick();

    // round-robin bursts
    do_reset();
    for (int b = 0; b < 2; b++) begin
      got_c.delete();
      for (int c = 0; c < NC; c++) drive(c, 32'h1500_0002, 1'b0, 5'd0, 32'h0);
      tick();
      for (int i = 0; i < 8; i++) begin
        if (bus.evt_valid) got_c.push_back(int'(bus.evt_core));
        tick();
      end
      chk($sformatf("rr%0d_count", b), 64'(got_c.size()), 4);
      for (int i = 0; i < 4; i++)
        chk($sformatf("rr%0d_order%0d", b, i), 64'((i < got_c.size()) ? got_c[i] : 15), 64'(i));
    end

    // backpressure and overflow
    do_reset();
    bus.evt_ready = 1'b0;
    for (int k = 0; k < 12; k++) begin
      drive(2, 32'h1500_0002, 1'b1, 5'd3, 32'(100 + k));
      tick();
    end
    chk("ovf_flag", overflow, 1);
    chk("ovf_drops", drop_count, 3);
    for (int i = 0; i < 3; i++) begin
      chk("ovf_hold_valid", bus.evt_valid, 1);
      chk("ovf_hold_core", bus.evt_core, 2);
      chk("ovf_hold_data", bus.evt_data, 100);
      tick();
    end
    bus.evt_ready = 1'b1;
    got_d.delete();
    for (int i = 0; i < 20; i++) begin
      if (bus.evt_valid) got_d.push_back(bus.evt_data);
      tick();
    end
    chk("drain_count", 64'(got_d.size()), 9);
    for (int i = 0; i < 9; i++)
      chk($sformatf("drain%0d", i), (i < got_d.size()) ? 64'(got_d[i]) : 64'hDEAD, 64'(100 + i));
    chk("drain_drops", drop_count, 3);

    // completion
    do_reset();
    for (int c = 0; c < NC; c++) drive(c, 32'h1500_0001, 1'b1, 5'd3, 32'(c));
    tick();
    popped = 0;
    for (int i = 0; i < 30 && !all_done; i++) begin
      if (bus.evt_valid) begin
        chk("done_evt_type", bus.evt_type, 0);
        chk("done_evt_data", bus.evt_data, 64'(popped));
        popped++;
      end
      tick();
    end
    chk("done_flag", all_done, 1);
    chk("done_popped", 64'(popped), 4);
    chk("done_term", core_terminated, 4'hF);
    for (int k = 0; k < 3; k++) begin
      for (int c = 0; c < NC; c++) drive(c, 32'h1500_0002, 1'b0, 5'd0, 32'h0);
      tick();
    end
    for (int k = 0; k < 4; k++) begin
      chk("after_done_quiet", bus.evt_valid, 0);
      tick();
    end
    for (int k = 0; k < 110; k++) tick();
    chk("done_no_timeout", timeout, 0);
    chk("done_sticky", all_done, 1);

    // timeout, then reset with events queued
    do_reset();
    for (int i = 1; i <= int'(TMO); i++) begin
      if (i == 5) drive(3, 32'h1500_0002, 1'b0, 5'd0, 32'h0);
      tick();
      if (i == int'(TMO) - 1) chk("to_before", timeout, 0);
    end
    chk("to_at", timeout, 1);
    bus.evt_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      for (int c = 0; c < 3; c++) drive(c, 32'h1500_0002, 1'b0, 5'd0, 32'h0);
      tick();
    end
    chk("pre_rst_ovf", overflow, 1);
    chk("pre_rst_valid", bus.evt_valid, 1);
    do_reset();
    chk("post_rst_valid", bus.evt_valid, 0);
    chk("post_rst_timeout", timeout, 0);
    chk("post_rst_drops", drop_count, 0);
    chk("post_rst_ovf", overflow, 0);
    chk("post_rst_data", bus.evt_data, 0);
    bus.evt_ready = 1'b1;

    // random traffic
    for (int n = 0; n < 400; n++) begin
      if (n == 200) do_reset();
      bus.evt_ready = ($urandom_range(0, 3) != 0);
      for (int c = 0; c < NC; c++) begin
        if ($urandom_range(0, 2) == 0) begin
          int r;
          r = $urandom_range(0, 99);
          if (r < 2)       ins = 32'h1500_0001;
          else if (r < 30) ins = 32'h1500_0002;
          else if (r < 55) ins = 32'h1500_0004;
          else if (r < 65) ins = 32'h1500_0003;
          else begin
            ins = $urandom;
            if (ins[31:24] == 8'h15) ins[31:24] = 8'h9c;
          end
          if (ins[31:24] == 8'h15) ins[23:16] = 8'($urandom_range(0, 255));
          drive(c, ins, 1'($urandom_range(0, 1)),
                ($urandom_range(0, 1) != 0) ? 5'd3 : 5'($urandom_range(0, 31)), $urandom);
        end
      end
      tick();
    end
    bus.evt_ready = 1'b1;
    for (int k = 0; k < 30; k++) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
